// File: rtl/serial_adder_sub.sv
// Digit-serial signed/unsigned add/subtract: DIGIT bits per clock, start/done handshake,
// WIDTH+1-bit result plus carry/borrow (unsigned) or overflow (signed) flag.
module serial_adder_sub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iStart,
  input  logic             iSA,
  input  logic             iSub,
  input  logic [WIDTH-1:0] iData_a,
  input  logic [WIDTH-1:0] iData_b,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH:0]   oData,
  output logic             oData_C
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : gBadParams
      $error("serial_adder_sub: illegal WIDTH/DIGIT combination");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, stateNext;

  logic [WIDTH-1:0] aReg, bReg, sumReg, sumFull;
  logic             saReg, subReg, carry;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] digitA, digitB, digitSum;
  logic             digitCout;
  logic             accept, lastDigit;
  logic [WIDTH+1:0] result;
  int               bitPos;

  // Packs {flag, data}; the carry into the MSB is recovered from the MSB sum bit itself.
  function automatic logic [WIDTH+1:0] formatResult(
    input logic [WIDTH-1:0] sum,
    input logic             cout,
    input logic             aMsb,
    input logic             bMsb,
    input logic             sa,
    input logic             sub
  );
    logic cMsb, msb, flag;
    cMsb = aMsb ^ bMsb ^ sum[WIDTH-1];
    if (sa) begin
      msb  = aMsb ^ bMsb ^ cout;
      flag = cout ^ cMsb;
    end else if (sub) begin
      msb  = ~cout;
      flag = ~cout;
    end else begin
      msb  = cout;
      flag = cout;
    end
    return {flag, msb, sum};
  endfunction

  assign accept    = iStart && (state == IDLE || state == DONE);
  assign lastDigit = (cnt == CW'(N - 1));
  assign oBusy     = (state == RUN);
  assign oDone     = (state == DONE);

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (iStart) stateNext = RUN;
      RUN:     if (lastDigit) stateNext = DONE;
      DONE:    stateNext = iStart ? RUN : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) state <= IDLE;
    else         state <= stateNext;
  end

  always_comb begin
    bitPos   = int'(cnt) * DIGIT;
    digitA   = aReg[bitPos +: DIGIT];
    digitB   = bReg[bitPos +: DIGIT];
    {digitCout, digitSum} = {1'b0, digitA} + {1'b0, digitB} + {{DIGIT{1'b0}}, carry};
    sumFull  = sumReg;
    sumFull[bitPos +: DIGIT] = digitSum;
    result   = formatResult(sumFull, digitCout, aReg[WIDTH-1], bReg[WIDTH-1], saReg, subReg);
  end

  // Operand capture and digit accumulation
  always_ff @(posedge iClk) begin
    if (accept) begin
      aReg   <= iData_a;
      bReg   <= iData_b ^ {WIDTH{iSub}};
      saReg  <= iSA;
      subReg <= iSub;
      carry  <= iSub;
    end else if (state == RUN) begin
      sumReg <= sumFull;
      carry  <= digitCout;
    end
  end

  // Digit counter and result registers
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      cnt     <= '0;
      oData   <= '0;
      oData_C <= 1'b0;
    end else if (accept) begin
      cnt <= '0;
    end else if (state == RUN) begin
      cnt <= cnt + 1'b1;
      if (lastDigit) {oData_C, oData} <= result;
    end
  end

endmodule

// File: tb/tb_serial_adder_sub.sv
// Directed bench for serial_adder_sub: 8/2 arithmetic and handshake vectors, plus a
// 16-bit sweep over DIGIT = 1, 4, 16 against an arithmetic reference.
module tb_serial_adder_sub;

  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       start8, sa8, sub8;
  logic [7:0] a8, b8;
  logic       busy8, done8, c8;
  logic [8:0] data8;
  logic [8:0] lastData8;

  logic        start16, sa16, sub16;
  logic [15:0] a16, b16;
  logic        busy1, done1, c1, busy4, done4, c4, busyF, doneF, cF;
  logic [16:0] data1, data4, dataF;

  serial_adder_sub #(.WIDTH(8), .DIGIT(2)) u8 (
    .iClk(clk), .iRst_n(rstN), .iStart(start8), .iSA(sa8), .iSub(sub8),
    .iData_a(a8), .iData_b(b8), .oBusy(busy8), .oDone(done8), .oData(data8), .oData_C(c8));

  serial_adder_sub #(.WIDTH(16), .DIGIT(1)) u16d1 (
    .iClk(clk), .iRst_n(rstN), .iStart(start16), .iSA(sa16), .iSub(sub16),
    .iData_a(a16), .iData_b(b16), .oBusy(busy1), .oDone(done1), .oData(data1), .oData_C(c1));

  serial_adder_sub #(.WIDTH(16), .DIGIT(4)) u16d4 (
    .iClk(clk), .iRst_n(rstN), .iStart(start16), .iSA(sa16), .iSub(sub16),
    .iData_a(a16), .iData_b(b16), .oBusy(busy4), .oDone(done4), .oData(data4), .oData_C(c4));

  serial_adder_sub #(.WIDTH(16), .DIGIT(16)) u16d16 (
    .iClk(clk), .iRst_n(rstN), .iStart(start16), .iSA(sa16), .iSub(sub16),
    .iData_a(a16), .iData_b(b16), .oBusy(busyF), .oDone(doneF), .oData(dataF), .oData_C(cF));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] model16(input logic [15:0] a, input logic [15:0] b,
                                          input logic sa, input logic sub);
    logic [16:0] ea, eb, r;
    logic        c;
    ea = sa ? {a[15], a} : {1'b0, a};
    eb = sa ? {b[15], b} : {1'b0, b};
    r  = sub ? (ea - eb) : (ea + eb);
    c  = sa ? (r[16] ^ r[15]) : r[16];
    return {c, r};
  endfunction

  // Accepts at the next edge, then expects oDone exactly 4 edges later with the
  // previous result held until then. hold keeps iStart high and scrambles operands in RUN.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sa, input logic sub,
                      input logic hold, input logic [8:0] expD, input logic expC, input string tag);
    a8 = a; b8 = b; sa8 = sa; sub8 = sub; start8 = 1'b1;
    @(posedge clk); #1;
    if (!hold) start8 = 1'b0;
    check({tag, "-busy-accept"}, busy8, 1);
    check({tag, "-done-accept"}, done8, 0);
    for (int k = 1; k <= 4; k++) begin
      if (hold) begin
        a8 = a8 ^ 8'hA5; b8 = b8 + 8'h3C; sa8 = ~sa8; sub8 = ~sub8;
      end
      @(posedge clk); #1;
      if (k < 4) begin
        check({tag, "-done-early"}, done8, 0);
        check({tag, "-data-held"}, data8, lastData8);
      end else begin
        check({tag, "-done"}, done8, 1);
        check({tag, "-busy-done"}, busy8, 0);
        check({tag, "-data"}, data8, expD);
        check({tag, "-c"}, c8, expC);
      end
    end
    start8 = 1'b0;
    lastData8 = expD;
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic sa,
                       input logic sub, input string tag);
    logic [17:0] exp;
    int lat1, lat4, latF;
    exp = model16(a, b, sa, sub);
    lat1 = 0; lat4 = 0; latF = 0;
    a16 = a; b16 = b; sa16 = sa; sub16 = sub; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done1 && lat1 == 0) lat1 = k;
      if (done4 && lat4 == 0) lat4 = k;
      if (doneF && latF == 0) latF = k;
    end
    check({tag, "-lat-d1"}, lat1, 16);
    check({tag, "-lat-d4"}, lat4, 4);
    check({tag, "-lat-d16"}, latF, 1);
    check({tag, "-data-d1"}, data1, exp[16:0]);
    check({tag, "-data-d4"}, data4, exp[16:0]);
    check({tag, "-data-d16"}, dataF, exp[16:0]);
    check({tag, "-c-d1"}, c1, exp[17]);
    check({tag, "-c-d4"}, c4, exp[17]);
    check({tag, "-c-d16"}, cF, exp[17]);
    check({tag, "-idle-busy"}, {busy1, busy4, busyF}, 0);
  endtask

  initial begin
    logic sawDone;
    rstN = 1'b0;
    start8 = 1'b0; sa8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
    start16 = 1'b0; sa16 = 1'b0; sub16 = 1'b0; a16 = '0; b16 = '0;
    lastData8 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst-busy", busy8, 0);
    check("rst-done", done8, 0);
    check("rst-data", data8, 0);
    check("rst-c", c8, 0);
    check("rst-data16", data1, 0);
    rstN = 1'b1;

    run8(8'h08, 8'h07, 1'b0, 1'b0, 1'b0, 9'h00F, 1'b0, "uadd-08-07");
    run8(8'hFF, 8'h80, 1'b0, 1'b0, 1'b0, 9'h17F, 1'b1, "uadd-ff-80");
    run8(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 9'h1FE, 1'b1, "uadd-ff-ff");
    run8(8'h80, 8'h80, 1'b1, 1'b0, 1'b0, 9'h100, 1'b1, "sadd-80-80");
    run8(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 9'h1FE, 1'b0, "sadd-ff-ff");
    run8(8'h08, 8'h08, 1'b1, 1'b0, 1'b0, 9'h010, 1'b0, "sadd-08-08");
    run8(8'h05, 8'h08, 1'b0, 1'b1, 1'b0, 9'h1FD, 1'b1, "usub-05-08");
    run8(8'h80, 8'h01, 1'b1, 1'b1, 1'b0, 9'h17F, 1'b1, "ssub-80-01");
    run8(8'h01, 8'h01, 1'b1, 1'b1, 1'b0, 9'h000, 1'b0, "ssub-01-01");

    // iStart held and operands scrambled throughout RUN
    run8(8'h10, 8'h20, 1'b0, 1'b0, 1'b1, 9'h030, 1'b0, "hold-10-20");
    @(posedge clk); #1;
    check("hold-idle-done", done8, 0);
    check("hold-idle-data", data8, 9'h030);

    // Back-to-back: second request lands in the DONE cycle of the first
    run8(8'h11, 8'h22, 1'b0, 1'b0, 1'b0, 9'h033, 1'b0, "b2b-first");
    run8(8'h40, 8'h01, 1'b1, 1'b1, 1'b0, 9'h03F, 1'b0, "b2b-second");
    @(posedge clk); #1;
    check("b2b-idle-done", done8, 0);
    check("b2b-idle-busy", busy8, 0);

    // Reset two edges after accept discards the operation
    a8 = 8'h33; b8 = 8'h44; sa8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    @(posedge clk); #1;
    rstN = 1'b0;
    @(posedge clk); #1;
    check("rstrun-busy", busy8, 0);
    check("rstrun-done", done8, 0);
    check("rstrun-data", data8, 0);
    check("rstrun-c", c8, 0);
    rstN = 1'b1;
    sawDone = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      sawDone = sawDone | done8;
    end
    check("rstrun-no-done", sawDone, 0);
    lastData8 = '0;
    run8(8'h33, 8'h44, 1'b0, 1'b0, 1'b0, 9'h077, 1'b0, "rstrun-fresh");

    run16(16'hFFFF, 16'h0001, 1'b0, 1'b0, "w16-uadd-edge");
    run16(16'h8000, 16'h0001, 1'b1, 1'b1, "w16-ssub-edge");
    run16(16'($urandom), 16'($urandom), 1'b0, 1'b0, "w16-uadd-rnd");
    run16(16'($urandom), 16'($urandom), 1'b0, 1'b1, "w16-usub-rnd");
    run16(16'($urandom), 16'($urandom), 1'b1, 1'b0, "w16-sadd-rnd");
    run16(16'($urandom), 16'($urandom), 1'b1, 1'b1, "w16-ssub-rnd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
